// File: rtl/motor_pwm_driver.sv
// Dual H-bridge PWM driver with period-aligned shadow registers and coast dead-time on reversal.
// Optional soft-start duty ramp is enabled by defining MOTOR_PWM_RAMP_EN.
module motor_pwm_driver #(
  parameter logic [11:0] PWM_TOP      = 12'h999,
  parameter int unsigned DEAD_PERIODS = 4,
  parameter logic [11:0] RAMP_STEP    = 12'h040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  directie_driverA,
  input  logic [1:0]  directie_driverB,
  input  logic [11:0] factor_dc_driverA,
  input  logic [11:0] factor_dc_driverB,
  output logic [1:0]  in_a,
  output logic [1:0]  in_b,
  output logic        pwm_a,
  output logic        pwm_b,
  output logic        period_start,
  output logic        dead_a,
  output logic        dead_b
);

  localparam int DCW = (DEAD_PERIODS < 2) ? 1 : $clog2(DEAD_PERIODS + 1);
  localparam logic [DCW-1:0] DEAD_LOAD = DCW'(DEAD_PERIODS);
`ifdef MOTOR_PWM_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif
  // A step of PWM_TOP saturates to the target in one boundary, i.e. no ramp.
  localparam logic [11:0] STEP = RAMP_EN ? RAMP_STEP : PWM_TOP;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD, S_BRAKE} state_t;

  logic [11:0] cnt_q;
  logic        period_start_q;
  logic        boundary;

  assign boundary = (cnt_q == 12'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= 12'd0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= (cnt_q == PWM_TOP - 12'd1) ? 12'd0 : cnt_q + 12'd1;
      period_start_q <= boundary;
    end
  end

  logic [1:0][1:0]  dir_req;
  logic [1:0][11:0] duty_req;
  logic [1:0][1:0]  pin;
  logic [1:0]       pwm;
  logic [1:0]       dead;

  assign dir_req  = {directie_driverB, directie_driverA};
  assign duty_req = {factor_dc_driverB, factor_dc_driverA};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      state_t         state_q, state_d;
      logic [1:0]     dir_q, dir_d, pend_q, pend_d;
      logic [DCW-1:0] dcnt_q, dcnt_d;
      logic [11:0]    duty_q, duty_d, target;
      logic [12:0]    ramp_sum;
      logic           drive;
      logic [1:0]     pin_q, pin_d;
      logic           pwm_q, pwm_d, dead_q, dead_d;

      assign drive  = (dir_req[gi] == 2'b10) || (dir_req[gi] == 2'b01);
      assign target = (duty_req[gi] > PWM_TOP) ? PWM_TOP : duty_req[gi];

      always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        dcnt_d   = dcnt_q;
        duty_d   = duty_q;
        ramp_sum = 13'd0;
        if (boundary) begin
          unique case (state_q)
            S_RUN: begin
              if (!drive) begin
                state_d = S_BRAKE;
              end else if (dir_req[gi] != dir_q) begin
                state_d = S_DEAD;
                dcnt_d  = DEAD_LOAD;
                pend_d  = dir_req[gi];
              end
            end
            S_DEAD: begin
              if (!drive) begin
                state_d = S_BRAKE;
                dcnt_d  = '0;
              end else begin
                pend_d = dir_req[gi];
                // The count was loaded at entry, so leaving at 1 gives DEAD_PERIODS full periods.
                if (dcnt_q <= DCW'(1)) begin
                  state_d = S_RUN;
                  dir_d   = pend_d;
                  dcnt_d  = '0;
                end else begin
                  dcnt_d = dcnt_q - DCW'(1);
                end
              end
            end
            default: begin
              if (drive) begin
                state_d = S_RUN;
                dir_d   = dir_req[gi];
              end else begin
                state_d = S_BRAKE;
              end
            end
          endcase
          ramp_sum = ((state_q == S_RUN && state_d == S_RUN) ? {1'b0, duty_q} : 13'd0)
                     + {1'b0, STEP};
          duty_d   = (state_d != S_RUN) ? 12'd0 :
                     (ramp_sum > {1'b0, target}) ? target : ramp_sum[11:0];
        end
      end

      always_comb begin
        pin_d  = 2'b00;
        pwm_d  = 1'b0;
        dead_d = (state_d == S_DEAD);
        if (state_d == S_RUN) begin
          pin_d = dir_d;
          pwm_d = (cnt_q < duty_d);
        end else if (state_d == S_BRAKE) begin
          pin_d = 2'b11;
          pwm_d = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= S_IDLE;
          dir_q   <= 2'b00;
          pend_q  <= 2'b00;
          dcnt_q  <= '0;
          duty_q  <= 12'd0;
          pin_q   <= 2'b00;
          pwm_q   <= 1'b0;
          dead_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          dir_q   <= dir_d;
          pend_q  <= pend_d;
          dcnt_q  <= dcnt_d;
          duty_q  <= duty_d;
          pin_q   <= pin_d;
          pwm_q   <= pwm_d;
          dead_q  <= dead_d;
        end
      end

      assign pin[gi]  = pin_q;
      assign pwm[gi]  = pwm_q;
      assign dead[gi] = dead_q;
    end
  endgenerate

  assign in_a         = pin[0];
  assign in_b         = pin[1];
  assign pwm_a        = pwm[0];
  assign pwm_b        = pwm[1];
  assign dead_a       = dead[0];
  assign dead_b       = dead[1];
  assign period_start = period_start_q;

endmodule
